imem_loader: RTL and testbench

- Writer side of the instruction stream that the control unit decodes.
- Receives a byte stream over a valid/ready interface and packs each group of 4 bytes little-endian into one 32-bit RV32I instruction word.
- Writes each packed word into instruction memory at consecutive word addresses.
- Holds the CPU (`cpu_hold`) until the requested number of words has been written, then releases it.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_byte_packer.sv | 50 +++++
 rtl/imem_loader.sv | 140 ++++++++++++++
 tb/tb_imem_loader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader: FSM state
// encoding and the byte-packing geometry of one RV32I word.
package loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_IDX_W     = 2;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Collects bytes little-endian into a 32-bit word and flags the cycle in
// which the last byte of a word is accepted.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_word_full
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(BYTES_PER_WORD - 1);

    logic [BYTE_IDX_W-1:0] r_idx;
    logic [31:0]           r_word;
    logic [31:0]           w_word;

    // Current word with the incoming byte inserted at its lane
    always_comb begin
        w_word = r_word;
        for (int b = 0; b < BYTES_PER_WORD; b++) begin
            if (r_idx == BYTE_IDX_W'(b)) begin
                w_word[8*b +: 8] = i_byte;
            end else begin
                w_word[8*b +: 8] = r_word[8*b +: 8];
            end
        end
    end

    // Byte index and partial-word storage; the index wraps to 0 after lane 3
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_word <= 32'h0000_0000;
        end else if (i_clear) begin
            r_idx  <= '0;
            r_word <= 32'h0000_0000;
        end else if (i_accept) begin
            r_idx  <= r_idx + BYTE_IDX_W'(1);
            r_word <= w_word;
        end
    end

    assign o_word      = w_word;
    assign o_word_full = i_accept && (r_idx == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as packed 32-bit words and
// holds the CPU until the requested number of words has been written.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W  = 6,
    parameter int N_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err_len
);

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W + 1)'(N_WORDS);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_wcnt;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_err_len;

    logic              w_start_seen;
    logic              w_len_bad;
    logic              w_len_zero;
    logic              w_load;
    logic              w_accept;
    logic              w_word_full;
    logic [31:0]       w_word;

    assign w_len_bad  = (len > MAX_LEN);
    assign w_len_zero = (len == (ADDR_W + 1)'(0));
    assign w_load     = w_start_seen && !w_len_bad && !w_len_zero;
    assign w_accept   = byte_valid && (r_state == ST_RECV);

    byte_packer u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (w_load),
        .i_accept    (w_accept),
        .i_byte      (byte_data),
        .o_word      (w_word),
        .o_word_full (w_word_full)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; DONE shares the IDLE start decision so a reload needs no extra cycle
    always_comb begin
        w_state_nxt  = r_state;
        w_start_seen = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start_seen = 1'b1;
                    if (w_len_bad) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_len_zero) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RECV;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RECV: begin
                if (w_word_full) begin
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_RECV;
                end
            end
            ST_WRITE: begin
                if ((r_wcnt + (ADDR_W + 1)'(1)) == r_len) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RECV;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Length latch, word counter, write address/data and the sticky length error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len     <= '0;
            r_wcnt    <= '0;
            r_waddr   <= '0;
            r_wdata   <= 32'h0000_0000;
            r_err_len <= 1'b0;
        end else begin
            if (w_start_seen) begin
                r_err_len <= w_len_bad;
            end
            if (w_load) begin
                r_len  <= len;
                r_wcnt <= '0;
            end
            if (w_word_full) begin
                r_waddr <= r_wcnt[ADDR_W-1:0];
                r_wdata <= w_word;
            end
            if (r_state == ST_WRITE) begin
                r_wcnt <= r_wcnt + (ADDR_W + 1)'(1);
            end
        end
    end

    // Reset suppresses a write even when it lands in the WRITE cycle itself
    assign we         = (r_state == ST_WRITE) && rst_n;
    assign byte_ready = (r_state == ST_RECV);
    assign cpu_hold   = (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign err_len    = r_err_len;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected writes are queued as bytes
// are driven and compared against every we pulse.
module tb_imem_loader;

    localparam int ADDR_W  = 6;
    localparam int N_WORDS = 64;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              cpu_hold;
    logic              done;
    logic              err_len;

    int n_checks;
    int n_errors;
    logic [ADDR_W+31:0] exp_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .N_WORDS(N_WORDS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .err_len    (err_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every we pulse must match the oldest queued write
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_we", 32'(waddr), 32'hFFFF_FFFF);
            end else begin
                logic [ADDR_W+31:0] e;
                e = exp_q.pop_front();
                check_eq("waddr", 32'(waddr), 32'(e[ADDR_W+31:32]));
                check_eq("wdata", wdata, e[31:0]);
            end
        end
    end

    task automatic do_start(input logic [ADDR_W:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n          = 0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (byte_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check_eq("byte_timeout", 32'(n), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [ADDR_W-1:0] a, input logic [31:0] w, input int gap);
        exp_q.push_back({a, w});
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
            if (i < 3) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check_eq("we_early", 32'(we), 32'd0);
                end
            end
        end
        check_eq("we_latency", 32'(we), 32'd1);
    endtask

    initial begin
        logic [31:0] partial;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; start = 1'b0; len = '0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", 32'(byte_ready), 32'd0);
        check_eq("rst_we",    32'(we),         32'd0);
        check_eq("rst_waddr", 32'(waddr),      32'd0);
        check_eq("rst_wdata", wdata,           32'd0);
        check_eq("rst_hold",  32'(cpu_hold),   32'd1);
        check_eq("rst_done",  32'(done),       32'd0);
        check_eq("rst_err",   32'(err_len),    32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Oversize length is rejected and the loader stays idle
        do_start(7'(N_WORDS + 1));
        check_eq("ovr_err",   32'(err_len),    32'd1);
        check_eq("ovr_hold",  32'(cpu_hold),   32'd1);
        check_eq("ovr_ready", 32'(byte_ready), 32'd0);
        check_eq("ovr_done",  32'(done),       32'd0);

        // Single word with gaps; the start also clears err_len
        do_start(7'd1);
        check_eq("gap_err_clr", 32'(err_len),    32'd0);
        check_eq("gap_ready",   32'(byte_ready), 32'd1);
        send_word(6'd0, 32'h0000_006F, 3);
        @(negedge clk);
        check_eq("gap_done", 32'(done),     32'd1);
        check_eq("gap_hold", 32'(cpu_hold), 32'd0);

        // Empty load, with bytes offered that must not be taken
        do_start(7'd0);
        byte_valid = 1'b1; byte_data = 8'h55;
        check_eq("empty_done",  32'(done),       32'd1);
        check_eq("empty_hold",  32'(cpu_hold),   32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("empty_ready", 32'(byte_ready), 32'd0);
        end
        byte_valid = 1'b0;

        // Basic two-word load
        do_start(7'd2);
        check_eq("basic_hold", 32'(cpu_hold), 32'd1);
        send_word(6'd0, 32'h0050_0513, 0);
        send_word(6'd1, 32'h00A0_0593, 0);
        @(negedge clk);
        check_eq("basic_done", 32'(done),     32'd1);
        check_eq("basic_hold_rel", 32'(cpu_hold), 32'd0);

        // Reload from DONE
        do_start(7'd1);
        check_eq("reload_hold", 32'(cpu_hold), 32'd1);
        check_eq("reload_done", 32'(done),     32'd0);
        send_word(6'd0, 32'h0000_0013, 0);
        @(negedge clk);
        check_eq("reload_done2", 32'(done), 32'd1);

        // Reset in the middle of the second word discards the partial bytes
        do_start(7'd2);
        send_word(6'd0, 32'h1122_3344, 0);
        partial = 32'h0000_EEFF;
        send_byte(partial[7:0]);
        send_byte(partial[15:8]);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("mid_rst_hold",  32'(cpu_hold),   32'd1);
        check_eq("mid_rst_ready", 32'(byte_ready), 32'd0);
        do_start(7'd1);
        send_word(6'd0, 32'hDDCC_BBAA, 0);
        @(negedge clk);
        check_eq("mid_rst_done", 32'(done), 32'd1);

        repeat (3) @(negedge clk);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
